// File: rtl/chassis_cmd_parser.sv
// Frame parser for the host UART link: AA 55 CMD LEN PAYLOAD[LEN] CHK frames drive the
// wheel setpoints. An inter-byte gap timer aborts stalled frames; a watchdog zeroes the wheels.
module chassis_cmd_parser #(
  parameter int MAX_LEN     = 8,
  parameter int GAP_CYCLES  = 25000,
  parameter int WDOG_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic [15:0] speed_l,
  output logic [15:0] speed_r,
  output logic [7:0]  cmd_code,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        wdog_timeout,
  output logic        busy
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);

  typedef enum logic [2:0] {HDR0, HDR1, CMD, LEN, PAY, CHK} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, len_q, sum_q, pay_rem;
  logic [IDX_W-1:0]  pay_idx;
  logic [7:0]        pay_buf [MAX_LEN];
  logic [GAP_W-1:0]  gap_cnt;
  logic [WDOG_W-1:0] wdog_cnt;

  logic gap_expire, len_err, chk_ok, chk_bad;
  logic is_speed, is_stop, dispatch_bad, valid_ev, err_ev, wdog_expire;

  assign busy = (state_q != HDR0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HDR0;
    else     state_q <= state_d;
  end

  // A gap expiry aborts the frame even if a byte lands that cycle; that byte restarts the header hunt.
  always_comb begin
    state_d    = state_q;
    gap_expire = busy && (gap_cnt == GAP_LAST);
    len_err    = 1'b0;
    chk_ok     = 1'b0;
    chk_bad    = 1'b0;
    if (gap_expire) begin
      state_d = (rx_rdy && rx_data == 8'hAA) ? HDR1 : HDR0;
    end else if (rx_rdy) begin
      case (state_q)
        HDR0: if (rx_data == 8'hAA) state_d = HDR1;
        HDR1: begin
          if (rx_data == 8'h55)      state_d = CMD;
          else if (rx_data != 8'hAA) state_d = HDR0;
        end
        CMD: state_d = LEN;
        LEN: begin
          if (rx_data > MAX_LEN_B) begin
            len_err = 1'b1;
            state_d = HDR0;
          end else if (rx_data == 8'd0) begin
            state_d = CHK;
          end else begin
            state_d = PAY;
          end
        end
        PAY: if (pay_rem == 8'd1) state_d = CHK;
        CHK: begin
          state_d = HDR0;
          if (rx_data == sum_q) chk_ok  = 1'b1;
          else                  chk_bad = 1'b1;
        end
        default: state_d = HDR0;
      endcase
    end
  end

  assign is_speed     = (cmd_q == 8'h01);
  assign is_stop      = (cmd_q == 8'h02);
  assign dispatch_bad = chk_ok && ((is_speed && len_q != 8'd4) || (is_stop && len_q != 8'd0));
  assign valid_ev     = chk_ok && !dispatch_bad;
  assign err_ev       = gap_expire || len_err || chk_bad || dispatch_bad;
  assign wdog_expire  = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      pay_rem <= '0;
      pay_idx <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < MAX_LEN; i++) pay_buf[i] <= '0;
    end else begin
      if (rx_rdy || !busy || gap_expire) gap_cnt <= '0;
      else                               gap_cnt <= gap_cnt + GAP_W'(1);
      if (rx_rdy && !gap_expire) begin
        case (state_q)
          CMD: begin
            cmd_q <= rx_data;
            sum_q <= rx_data;
          end
          LEN: begin
            len_q   <= rx_data;
            pay_rem <= rx_data;
            pay_idx <= '0;
            sum_q   <= sum_q + rx_data;
          end
          PAY: begin
            pay_buf[pay_idx] <= rx_data;
            pay_idx          <= pay_idx + IDX_W'(1);
            pay_rem          <= pay_rem - 8'd1;
            sum_q            <= sum_q + rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  // A frame dispatched on the watchdog expiry cycle takes priority over the forced stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_l      <= '0;
      speed_r      <= '0;
      cmd_code     <= '0;
      cmd_valid    <= 1'b0;
      frame_err    <= 1'b0;
      err_cnt      <= '0;
      wdog_timeout <= 1'b0;
      wdog_cnt     <= '0;
    end else begin
      cmd_valid <= valid_ev;
      frame_err <= err_ev;
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (valid_ev) begin
        wdog_cnt     <= '0;
        wdog_timeout <= 1'b0;
        cmd_code     <= cmd_q;
        if (is_speed) begin
          speed_l <= {pay_buf[0], pay_buf[1]};
          speed_r <= {pay_buf[2], pay_buf[3]};
        end else if (is_stop) begin
          speed_l <= '0;
          speed_r <= '0;
        end
      end else begin
        if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + WDOG_W'(1);
        if (wdog_expire) begin
          wdog_timeout <= 1'b1;
          speed_l      <= '0;
          speed_r      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chassis_cmd_parser.sv
// Self-checking bench for chassis_cmd_parser: a queue-based frame model checked every cycle,
// plus literal expectations for the directed frames, gap and watchdog boundaries.
module tb_chassis_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam int GAP     = 50;
  localparam int WDOG    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_rdy = 1'b0;
  logic [15:0] speed_l, speed_r;
  logic [7:0]  cmd_code, err_cnt;
  logic        cmd_valid, frame_err, wdog_timeout, busy;

  int total = 0;
  int bad   = 0;

  // model state: header hunt flag, bytes collected after AA 55, timestamps in clock edges
  bit          aa_seen, collecting;
  logic [7:0]  frm[$];
  int          cyc, last_byte, wdog_last;
  logic [15:0] m_speed_l, m_speed_r;
  logic [7:0]  m_cmd_code, m_err_cnt;
  bit          m_cmd_valid, m_frame_err, m_timeout;

  chassis_cmd_parser #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .speed_l(speed_l), .speed_r(speed_r), .cmd_code(cmd_code), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .err_cnt(err_cnt), .wdog_timeout(wdog_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("speed_l", speed_l, m_speed_l);
    checkValue("speed_r", speed_r, m_speed_r);
    checkValue("cmd_code", cmd_code, m_cmd_code);
    checkValue("cmd_valid", cmd_valid, m_cmd_valid);
    checkValue("frame_err", frame_err, m_frame_err);
    checkValue("err_cnt", err_cnt, m_err_cnt);
    checkValue("wdog_timeout", wdog_timeout, m_timeout);
    checkValue("busy", busy, aa_seen || collecting);
  endtask

  task automatic modelReset();
    aa_seen = 0; collecting = 0; frm.delete();
    cyc = 0; last_byte = 0; wdog_last = 0;
    m_speed_l = 0; m_speed_r = 0; m_cmd_code = 0; m_err_cnt = 0;
    m_cmd_valid = 0; m_frame_err = 0; m_timeout = 0;
  endtask

  task automatic modelStep(input bit rdy, input logic [7:0] data);
    bit err, valid;
    int s;
    cyc++;
    err = 0; valid = 0;
    if ((aa_seen || collecting) && (cyc - last_byte) == GAP) begin
      err = 1; aa_seen = 0; collecting = 0; frm.delete();
    end
    if (rdy) begin
      last_byte = cyc;
      if (collecting) begin
        frm.push_back(data);
        if (frm.size() == 2 && frm[1] > MAX_LEN) begin
          err = 1; collecting = 0; frm.delete();
        end else if (frm.size() >= 2 && frm.size() == int'(frm[1]) + 3) begin
          s = 0;
          for (int i = 0; i < frm.size() - 1; i++) s += frm[i];
          if (s % 256 != frm[frm.size()-1]) err = 1;
          else if (frm[0] == 8'h01) begin
            if (frm[1] == 4) begin
              valid = 1; m_speed_l = {frm[2], frm[3]}; m_speed_r = {frm[4], frm[5]};
            end else err = 1;
          end else if (frm[0] == 8'h02) begin
            if (frm[1] == 0) begin
              valid = 1; m_speed_l = 0; m_speed_r = 0;
            end else err = 1;
          end else valid = 1;
          if (valid) m_cmd_code = frm[0];
          collecting = 0; frm.delete();
        end
      end else if (aa_seen) begin
        if (data == 8'h55) begin collecting = 1; aa_seen = 0; end
        else if (data != 8'hAA) aa_seen = 0;
      end else if (data == 8'hAA) aa_seen = 1;
    end
    if (valid) begin
      m_timeout = 0; wdog_last = cyc;
    end else if (cyc - wdog_last == WDOG) begin
      m_timeout = 1; m_speed_l = 0; m_speed_r = 0;
    end
    m_cmd_valid = valid;
    m_frame_err = err;
    if (err && m_err_cnt != 8'hFF) m_err_cnt++;
  endtask

  task automatic applyStimulus(input bit rdy, input logic [7:0] data);
    rx_rdy  = rdy;
    rx_data = data;
    @(posedge clk);
    modelStep(rdy, data);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic sendBytes(input logic [7:0] q[$], input bit spaced);
    for (int i = 0; i < q.size(); i++) begin
      applyStimulus(1'b1, q[i]);
      if (spaced && i != q.size() - 1) begin
        if ($urandom_range(0, 29) == 0) idle($urandom_range(45, 55));
        else                            idle($urandom_range(0, 3));
      end
    end
  endtask

  task automatic buildFrame(input logic [7:0] cmd, input logic [7:0] pl[$],
                            input logic [7:0] chk_delta, output logic [7:0] fr[$]);
    logic [7:0] s;
    s = cmd + 8'(pl.size());
    fr = {8'hAA, 8'h55, cmd, 8'(pl.size())};
    foreach (pl[i]) begin fr.push_back(pl[i]); s = s + pl[i]; end
    fr.push_back(s + chk_delta);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pl[$];
    int kind, n;

    rx_rdy = 0;
    doReset();
    idle(3);

    // directed: valid speed frame
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8, 8'hFC, 8'h18, 8'h04}, 1'b0);
    checkValue("t1_cmd_valid", cmd_valid, 1);
    checkValue("t1_cmd_code", cmd_code, 8'h01);
    checkValue("t1_speed_l", speed_l, 16'h03E8);
    checkValue("t1_speed_r", speed_r, 16'hFC18);
    checkValue("t1_err_cnt", err_cnt, 0);
    idle(2);

    // directed: bad checksum then stop frame
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8, 8'hFC, 8'h18, 8'h05}, 1'b0);
    checkValue("t2_frame_err", frame_err, 1);
    checkValue("t2_err_cnt", err_cnt, 1);
    checkValue("t2_speed_l_kept", speed_l, 16'h03E8);
    idle(1);
    checkValue("t2_frame_err_pulse", frame_err, 0);
    sendBytes({8'hAA, 8'h55, 8'h02, 8'h00, 8'h02}, 1'b0);
    checkValue("t2_stop_valid", cmd_valid, 1);
    checkValue("t2_stop_speed_l", speed_l, 0);
    checkValue("t2_stop_speed_r", speed_r, 0);
    idle(2);

    // directed: oversize LEN
    sendBytes({8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h09}, 1'b0);
    checkValue("t3_len_err", frame_err, 1);
    checkValue("t3_busy", busy, 0);
    idle(2);
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8, 8'hFC, 8'h18, 8'h04}, 1'b1);
    checkValue("t3_recover", cmd_valid, 1);

    // directed: gap expiry
    sendBytes({8'hAA, 8'h55, 8'h01}, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b0, 8'h00);
      if (k == 49) begin
        checkValue("t4_no_err_yet", frame_err, 0);
        checkValue("t4_busy_yet", busy, 1);
      end
      if (k == 50) begin
        checkValue("t4_gap_err", frame_err, 1);
        checkValue("t4_gap_busy", busy, 0);
      end
    end
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h00, 8'h64, 8'hFF, 8'h9C, 8'h04}, 1'b0);
    checkValue("t4_recover", cmd_valid, 1);

    // gap expiry coinciding with a header byte
    sendBytes({8'hAA, 8'h55, 8'h01}, 1'b0);
    idle(49);
    applyStimulus(1'b1, 8'hAA);
    checkValue("t4b_abort", frame_err, 1);
    checkValue("t4b_rehunt", busy, 1);
    sendBytes({8'h55, 8'h01, 8'h04, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h23}, 1'b0);
    checkValue("t4b_valid", cmd_valid, 1);
    checkValue("t4b_speed_r", speed_r, 16'h0014);

    // directed: watchdog expiry and a frame landing on the expiry cycle
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8, 8'hFC, 8'h18, 8'h04}, 1'b0);
    for (int k = 1; k <= WDOG; k++) begin
      applyStimulus(1'b0, 8'h00);
      if (k == WDOG - 1) checkValue("t5_wdog_early", wdog_timeout, 0);
      if (k == WDOG) begin
        checkValue("t5_wdog_set", wdog_timeout, 1);
        checkValue("t5_wdog_speed_l", speed_l, 0);
        checkValue("t5_wdog_speed_r", speed_r, 0);
      end
    end
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h00, 8'h64, 8'hFF, 8'h9C, 8'h04}, 1'b0);
    checkValue("t5_clear", wdog_timeout, 0);
    checkValue("t5_new_speed_r", speed_r, 16'hFF9C);
    idle(WDOG - 9);
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h01, 8'hF4, 8'hFE, 8'h0C, 8'h04}, 1'b0);
    checkValue("t5_race_flag", wdog_timeout, 0);
    checkValue("t5_race_speed_l", speed_l, 16'h01F4);
    checkValue("t5_race_speed_r", speed_r, 16'hFE0C);
    idle(1);
    checkValue("t5_race_after", wdog_timeout, 0);

    // randomized frames, noise and gaps against the model
    for (int f = 0; f < 150; f++) begin
      pl.delete();
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        sendBytes(pl, 1'b1);
        pl.delete();
      end
      case (kind)
        0: begin
          for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
          buildFrame(8'h01, pl, 8'h00, fr);
        end
        1: buildFrame(8'h02, pl, 8'h00, fr);
        2: begin
          n = $urandom_range(0, MAX_LEN);
          for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
          buildFrame(8'($urandom_range(3, 255)), pl, 8'h00, fr);
        end
        3: begin
          n = $urandom_range(0, MAX_LEN);
          for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
          buildFrame(8'($urandom), pl, 8'($urandom_range(1, 255)), fr);
        end
        4: begin
          n = $urandom_range(0, MAX_LEN);
          if (n == 4) n = 5;
          for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
          buildFrame(8'($urandom_range(1, 2)), pl, 8'h00, fr);
        end
        default: fr = {8'hAA, 8'h55, 8'($urandom), 8'($urandom_range(MAX_LEN + 1, 255))};
      endcase
      sendBytes(fr, 1'b1);
      idle($urandom_range(0, 4));
    end

    // error counter saturation
    for (int f = 0; f < 300; f++) sendBytes({8'hAA, 8'h55, 8'h03, 8'h00, 8'h00}, 1'b0);
    idle(1);
    checkValue("t6_err_sat", err_cnt, 8'hFF);

    // reset mid-payload discards the frame silently
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8}, 1'b0);
    doReset();
    checkValue("t6_rst_err_cnt", err_cnt, 0);
    checkValue("t6_rst_busy", busy, 0);
    checkValue("t6_rst_speed_l", speed_l, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkValue("t6_no_err_after_rst", frame_err, 0);
    end
    sendBytes({8'hAA, 8'h55, 8'h01, 8'h04, 8'h03, 8'hE8, 8'hFC, 8'h18, 8'h04}, 1'b1);
    checkValue("t6_post_rst_valid", cmd_valid, 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chassis_cmd_parser.md
Name: chassis_cmd_parser

Overview:
Frame-level controller downstream of the UART byte receiver. It consumes received bytes (rx_data with its one-cycle rx_rdy strobe) and sequences them through a header/command/length/payload/checksum FSM. It validates each frame and configures the chassis drive setpoints (left/right wheel speed). A command watchdog zeroes the setpoints if the host link goes quiet.

Parameters:
MAX_LEN, 8, maximum payload bytes accepted (payload buffer depth)
GAP_CYCLES, 25000, max clk cycles between bytes inside a frame (1 ms at 25 MHz)
WDOG_CYCLES, 12500000, clk cycles without a valid frame before setpoints are forced to zero (0.5 s at 25 MHz)

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  reset; one clock, asynchronous, active-high
rx_data  input  8  received byte; valid only when rx_rdy=1
rx_rdy  input  1  one-cycle strobe; a new byte is on rx_data
speed_l  output  16  signed left wheel setpoint, two's complement
speed_r  output  16  signed right wheel setpoint, two's complement
cmd_code  output  8  CMD byte of the last checksum-valid frame
cmd_valid  output  1  one-cycle pulse; a checksum-valid frame completed
frame_err  output  1  one-cycle pulse; frame aborted or rejected
err_cnt  output  8  count of frame_err pulses, saturates at 255
wdog_timeout  output  1  level; watchdog expired, setpoints held at zero
busy  output  1  high whenever FSM is not in HDR0

Behaviour:
- Frame format: 0xAA 0x55 CMD LEN PAYLOAD[LEN] CHK. CHK = 8-bit modulo sum of CMD, LEN and all payload bytes.
- Reset: every output is 0; FSM in HDR0; payload buffer, checksum accumulator, gap and watchdog counters all 0.
- FSM states: HDR0, HDR1, CMD, LEN, PAY, CHK. The FSM advances only on cycles with rx_rdy=1.
  - HDR0: byte 0xAA goes to HDR1; any other byte stays in HDR0 (no error).
  - HDR1: 0x55 goes to CMD; 0xAA stays in HDR1; any other byte goes to HDR0 (no error).
  - CMD: latch CMD, sum = CMD, go to LEN.
  - LEN: if LEN > MAX_LEN, pulse frame_err and go to HDR0. If LEN = 0, go to CHK. Otherwise go to PAY. Add LEN to sum.
  - PAY: store byte at index 0..LEN-1 and add it to sum. After the LEN-th byte, go to CHK.
  - CHK: byte != sum gives frame_err and HDR0. Byte == sum dispatches the frame (below), then HDR0.
- Dispatch (registered; outputs change the cycle after the CHK-byte strobe):
  - CMD 0x01 with LEN=4: speed_l = {P0,P1}, speed_r = {P2,P3} (big-endian); cmd_valid pulse.
  - CMD 0x02 with LEN=0: speed_l = speed_r = 0; cmd_valid pulse.
  - CMD 0x01/0x02 with any other LEN: frame_err pulse; setpoints unchanged; no cmd_valid.
  - Any other CMD: cmd_valid pulse with cmd_code updated; setpoints unchanged.
  - Any cmd_valid clears wdog_timeout and resets the watchdog counter to 0.
- Gap timer:
  - Counts clk cycles while busy=1; cleared on every rx_rdy.
  - At GAP_CYCLES it pulses frame_err and returns the FSM to HDR0.
  - If rx_rdy arrives in the same cycle as expiry: the abort wins, and that byte is evaluated as an HDR0 byte in the same cycle.
- Watchdog:
  - Free-running counter, saturating at WDOG_CYCLES.
  - On reaching WDOG_CYCLES it sets wdog_timeout=1 and speed_l = speed_r = 0. The flag stays set until the next cmd_valid.
  - Valid frame in the same cycle as expiry: the frame wins. Setpoints take the frame values, the flag stays 0, and the counter resets.
  - The watchdog is not armed specially after reset; it counts from 0 immediately.
- err_cnt increments by 1 per frame_err pulse and holds at 255. frame_err and cmd_valid are never high in the same cycle.
- rst asserted mid-frame: immediate return to reset state; the partial frame is discarded with no error pulse.

Test Plan:
1. Send AA 55 01 04 03 E8 FC 18 04 -> one cycle after the last strobe: cmd_valid=1, cmd_code=0x01, speed_l=0x03E8 (+1000), speed_r=0xFC18 (-1000), err_cnt=0.
2. After test 1, send the same frame with CHK=05 -> frame_err one pulse, err_cnt=1, speeds unchanged at +1000/-1000; then send AA 55 02 00 02 -> cmd_valid, speed_l = speed_r = 0.
3. Send 12 AA AA 55 01 09 ... (LEN=9 > MAX_LEN) -> frame_err on the LEN strobe, FSM in HDR0 (busy=0); a subsequent valid frame is still accepted.
4. Gap: with GAP_CYCLES=50, send AA 55 01 then idle 60 cycles -> frame_err at cycle 50 after the last strobe, busy=0; then a full valid speed frame is accepted normally.
5. Watchdog: with WDOG_CYCLES=1000, apply the test-1 frame, then idle -> exactly 1000 cycles after cmd_valid, wdog_timeout=1 and speeds=0; a new valid frame clears the flag and loads its values. Also align a frame to land on the expiry cycle -> the frame values win.
6. Run 300 bad-checksum frames -> err_cnt saturates at 255. Assert rst mid-payload -> all outputs 0; no frame_err pulse.
